// File: rtl/buffer_pkg.sv
// Shared types and default sizing for the circular word buffer and its serial drain stage.
package buffer_pkg;

  localparam int BUF_DATA_WIDTH  = 16;
  localparam int BUF_COUNT_WIDTH = 4;
  localparam int TX_CLKS_PER_BIT = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_t;

endpackage

// File: rtl/buffer_tx_serializer_bit_timer.sv
// Bit-period down-counter: ticks on terminal count, reloads on tick or clear.
module bit_timer
  import buffer_pkg::*;
#(
  parameter int CLKS_PER_BIT = TX_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset)
      r_count <= '0;
    else if (i_clear || (r_count == '0))
      r_count <= RELOAD;
    else
      r_count <= r_count - TW'(1);
  end

  assign o_tick = (r_count == '0);

endmodule

// File: rtl/buffer_tx_serializer.sv
// Buffer drain stage: pops one word per frame and sends start, data MSB-first, optional
// even parity (BUFFER_TX_PARITY_EN), stop on a single-wire line.
//
// state  | meaning
// IDLE   | line high, waiting for enable and a non-empty buffer
// LOAD   | one-cycle pop of the head word into the shift register
// START  | start bit (low)
// DATA   | data bits, MSB first
// PARITY | even-parity bit (only with BUFFER_TX_PARITY_EN)
// STOP   | stop bit (high), then next LOAD or IDLE
module buffer_tx_serializer
  import buffer_pkg::*;
#(
  parameter int DATA_WIDTH   = BUF_DATA_WIDTH,
  parameter int COUNT_WIDTH  = BUF_COUNT_WIDTH,
  parameter int CLKS_PER_BIT = TX_CLKS_PER_BIT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_enable,
  input  logic [DATA_WIDTH-1:0]  i_head,
  input  logic [COUNT_WIDTH-1:0] i_count,
  output logic                   o_pull,
  output logic                   o_tx,
  output logic                   o_busy,
  output logic                   o_frame_done
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  tx_state_t             r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BIT_W-1:0]      r_bit_idx;
  logic                  w_tick;
  logic                  w_clear;
  logic                  w_start;
`ifdef BUFFER_TX_PARITY_EN
  logic                  r_parity;
`endif

  assign w_start = i_enable && (i_count != '0);

  // Timed states only exit on tick, where the timer reloads anyway; holding it
  // cleared through IDLE and LOAD therefore covers every state change.
  assign w_clear = (r_state == IDLE) || (r_state == LOAD);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock  (clock),
    .reset  (reset),
    .i_clear(w_clear),
    .o_tick (w_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_idx    <= '0;
      o_pull       <= 1'b0;
      o_tx         <= 1'b1;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
`ifdef BUFFER_TX_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      o_pull       <= 1'b0;
      o_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= LOAD;
            o_pull  <= 1'b1;
            o_busy  <= 1'b1;
          end
        end
        LOAD: begin
          r_shift   <= i_head;
          r_bit_idx <= '0;
`ifdef BUFFER_TX_PARITY_EN
          r_parity  <= ^i_head;
`endif
          o_tx      <= 1'b0;
          r_state   <= START;
        end
        START: begin
          if (w_tick) begin
            o_tx    <= r_shift[DATA_WIDTH-1];
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_BIT) begin
              r_bit_idx <= '0;
`ifdef BUFFER_TX_PARITY_EN
              o_tx      <= r_parity;
              r_state   <= PARITY;
`else
              o_tx      <= 1'b1;
              r_state   <= STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + BIT_W'(1);
              r_shift   <= r_shift << 1;
              o_tx      <= r_shift[DATA_WIDTH-2];
            end
          end
        end
`ifdef BUFFER_TX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            o_tx    <= 1'b1;
            r_state <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            o_frame_done <= 1'b1;
            if (w_start) begin
              r_state <= LOAD;
              o_pull  <= 1'b1;
            end else begin
              r_state <= IDLE;
              o_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          o_tx    <= 1'b1;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_tx_serializer.sv
// Directed bench for buffer_tx_serializer with a small queue standing in for the buffer.
module tb_buffer_tx_serializer;
  import buffer_pkg::*;

  localparam int DW   = 16;
  localparam int CW   = 4;
  localparam int CPB  = 4;
`ifdef BUFFER_TX_PARITY_EN
  localparam int P    = 1;
`else
  localparam int P    = 0;
`endif
  localparam int FL   = (DW + 2 + P) * CPB;
  localparam int MAXC = 260;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] head;
  logic [CW-1:0] count;
  logic          pull, tx, busy, frame_done;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_words[3];
  logic tr_tx[MAXC], tr_pull[MAXC], tr_busy[MAXC], tr_fd[MAXC];
  logic e_tx[MAXC], e_pull[MAXC], e_busy[MAXC], e_fd[MAXC];
  int   n_pulls;
  int   fd_first;

  always #5 clock = ~clock;

  buffer_tx_serializer #(
    .DATA_WIDTH(DW), .COUNT_WIDTH(CW), .CLKS_PER_BIT(CPB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .i_enable    (enable),
    .i_head      (head),
    .i_count     (count),
    .o_pull      (pull),
    .o_tx        (tx),
    .o_busy      (busy),
    .o_frame_done(frame_done)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    head   = '0;
    count  = '0;
    q.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  // Expected line level at offset off from the LOAD cycle of a frame carrying w.
  function automatic logic exp_tx_at(input logic [DW-1:0] w, input int off);
    int k;
    if (off < 1) return 1'b1;
    k = (off - 1) / CPB;
    if (k == 0) return 1'b0;
    if (k <= DW) return w[DW-k];
    if (P == 1 && k == DW + 1) return ^w;
    return 1'b1;
  endfunction

  // Frames start with LOAD at cycle 1 and follow each other with one LOAD cycle between.
  task automatic build_expected(input int nf);
    int l;
    l = 1;
    for (int c = 0; c < MAXC; c++) begin
      e_tx[c] = 1'b1; e_pull[c] = 1'b0; e_busy[c] = 1'b0; e_fd[c] = 1'b0;
    end
    for (int f = 0; f < nf; f++) begin
      e_pull[l] = 1'b1;
      for (int o = 0; o <= FL; o++) begin
        e_busy[l+o] = 1'b1;
        e_tx[l+o]   = exp_tx_at(exp_words[f], o);
      end
      e_fd[l+FL+1] = 1'b1;
      l = l + FL + 1;
    end
  endtask

  // Runs ncyc sample points, popping the queue on the edge that closes a pull cycle.
  task automatic capture(input int ncyc, input int drop_c);
    logic pull_prev;
    n_pulls   = 0;
    fd_first  = -1;
    enable    = 1'b1;
    pull_prev = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) step();
      if (pull_prev && q.size() > 0) q.delete(0);
      if (c == drop_c) enable = 1'b0;
      head  = (q.size() > 0) ? q[0] : '0;
      count = CW'(q.size());
      tr_tx[c] = tx; tr_pull[c] = pull; tr_busy[c] = busy; tr_fd[c] = frame_done;
      if (pull) n_pulls++;
      if (frame_done && fd_first < 0) fd_first = c;
      pull_prev = pull;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({tx, pull, busy, frame_done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_outputs: got tx/pull/busy/fd=%b, want 1000", {tx, pull, busy, frame_done});
    end
    checks++;
    if (dut.r_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, want IDLE", dut.r_state);
    end
    capture(51, -1);
    build_expected(0);
    for (int c = 0; c < 51; c++) begin
      checks++;
      if (tr_tx[c] !== 1'b1 || tr_pull[c] !== 1'b0 || tr_busy[c] !== 1'b0) begin
        errors++;
        $display("FAIL empty_idle cycle %0d: got tx=%b pull=%b busy=%b, want 1 0 0",
                 c, tr_tx[c], tr_pull[c], tr_busy[c]);
      end
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    q.push_back(16'hA5C3);
    exp_words[0] = 16'hA5C3;
    capture(FL + 8, -1);
    build_expected(1);
    for (int c = 0; c < FL + 8; c++) begin
      checks++;
      if (tr_tx[c] !== e_tx[c] || tr_pull[c] !== e_pull[c] || tr_busy[c] !== e_busy[c] || tr_fd[c] !== e_fd[c]) begin
        errors++;
        $display("FAIL single_frame cycle %0d: got tx=%b pull=%b busy=%b fd=%b, want %b %b %b %b",
                 c, tr_tx[c], tr_pull[c], tr_busy[c], tr_fd[c], e_tx[c], e_pull[c], e_busy[c], e_fd[c]);
      end
    end
    checks++;
    if (n_pulls !== 1) begin
      errors++;
      $display("FAIL single_pulls: got %0d, want 1", n_pulls);
    end
    checks++;
    if (fd_first !== 2 + FL) begin
      errors++;
      $display("FAIL single_frame_done: got cycle %0d, want %0d", fd_first, 2 + FL);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    q.push_back(16'h1234); q.push_back(16'hFFFF); q.push_back(16'h8001);
    exp_words[0] = 16'h1234; exp_words[1] = 16'hFFFF; exp_words[2] = 16'h8001;
    capture(3 * (FL + 1) + 8, -1);
    build_expected(3);
    for (int c = 0; c < 3 * (FL + 1) + 8; c++) begin
      checks++;
      if (tr_tx[c] !== e_tx[c] || tr_pull[c] !== e_pull[c] || tr_busy[c] !== e_busy[c] || tr_fd[c] !== e_fd[c]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got tx=%b pull=%b busy=%b fd=%b, want %b %b %b %b",
                 c, tr_tx[c], tr_pull[c], tr_busy[c], tr_fd[c], e_tx[c], e_pull[c], e_busy[c], e_fd[c]);
      end
    end
    checks++;
    if (n_pulls !== 3) begin
      errors++;
      $display("FAIL b2b_pulls: got %0d, want 3", n_pulls);
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    q.push_back(16'hC00C); q.push_back(16'h5555);
    exp_words[0] = 16'hC00C;
    capture(FL + 20, 30);
    build_expected(1);
    for (int c = 0; c < FL + 20; c++) begin
      checks++;
      if (tr_tx[c] !== e_tx[c] || tr_pull[c] !== e_pull[c] || tr_busy[c] !== e_busy[c] || tr_fd[c] !== e_fd[c]) begin
        errors++;
        $display("FAIL enable_drop cycle %0d: got tx=%b pull=%b busy=%b fd=%b, want %b %b %b %b",
                 c, tr_tx[c], tr_pull[c], tr_busy[c], tr_fd[c], e_tx[c], e_pull[c], e_busy[c], e_fd[c]);
      end
    end
    checks++;
    if (n_pulls !== 1 || q.size() !== 1) begin
      errors++;
      $display("FAIL enable_drop_pulls: got pulls=%0d left=%0d, want 1 1", n_pulls, q.size());
    end
    checks++;
    if (dut.r_state !== IDLE) begin
      errors++;
      $display("FAIL enable_drop_state: got %0d, want IDLE", dut.r_state);
    end
  endtask

  task automatic test_reset_midframe();
    int pulls_after;
    do_reset();
    q.push_back(16'h1234);
    capture(22, -1);
    reset = 1'b1;
    step();
    checks++;
    if ({tx, pull, busy, frame_done} !== 4'b1000 || dut.r_state !== IDLE) begin
      errors++;
      $display("FAIL midframe_reset: got tx/pull/busy/fd=%b state=%0d, want 1000 IDLE",
               {tx, pull, busy, frame_done}, dut.r_state);
    end
    reset = 1'b0;
    pulls_after = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (pull) pulls_after++;
    end
    checks++;
    if (pulls_after !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midframe_no_repull: got pulls=%0d busy=%b, want 0 0", pulls_after, busy);
    end
    head  = 16'h00FF;
    count = 4'd1;
    step();
    checks++;
    if (pull !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL start_latency_load: got pull=%b tx=%b, want 1 1", pull, tx);
    end
    count = 4'd0;
    step();
    checks++;
    if (pull !== 1'b0 || tx !== 1'b0) begin
      errors++;
      $display("FAIL start_latency_start: got pull=%b tx=%b, want 0 0", pull, tx);
    end
  endtask

`ifdef BUFFER_TX_PARITY_EN
  task automatic test_parity();
    do_reset();
    q.push_back(16'h0001);
    capture(FL + 6, -1);
    for (int c = 70; c < 74; c++) begin
      checks++;
      if (tr_tx[c] !== 1'b1) begin
        errors++;
        $display("FAIL parity_0001 cycle %0d: got %b, want 1", c, tr_tx[c]);
      end
    end
    checks++;
    if (fd_first !== 78) begin
      errors++;
      $display("FAIL parity_frame_len: got frame_done at %0d, want 78", fd_first);
    end
    do_reset();
    q.push_back(16'h0003);
    capture(FL + 6, -1);
    for (int c = 70; c < 74; c++) begin
      checks++;
      if (tr_tx[c] !== 1'b0) begin
        errors++;
        $display("FAIL parity_0003 cycle %0d: got %b, want 0", c, tr_tx[c]);
      end
    end
  endtask
`endif

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    head   = '0;
    count  = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_enable_drop();
    test_reset_midframe();
`ifdef BUFFER_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/buffer_tx_serializer.md
# buffer_tx_serializer

Downstream drain stage for the circular word buffer. It watches the buffer's occupancy count, pulls one word at a time from the buffer head, and transmits it on a single-wire serial line as a framed bit stream: start bit, data MSB-first, optional parity, stop bit. It is the buffer's only consumer and the sole driver of its `pull` input.

## Interface
- `DATA_WIDTH`, 16: word width; matches the buffer's word width.
- `COUNT_WIDTH`, 4: width of the occupancy count input; must represent 0..depth inclusive.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit; legal range is ≥ 2.
- `clock` input 1: system clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `enable` input 1: permits new frames to start.
- `head` input DATA_WIDTH: current buffer head word.
- `count` input COUNT_WIDTH: buffer occupancy.
- `pull` output 1: one-cycle pop request to the buffer.
- `tx` output 1: serial line; idles high.
- `busy` output 1: high from LOAD through STOP.
- `frame_done` output 1: one-cycle pulse after the last stop-bit cycle.

Reset is reset, synchronous, active-high. The clock is clock.

## Operation
- States: IDLE, LOAD, START, DATA, PARITY, STOP.
- IDLE
  - tx=1, busy=0, pull=0.
  - If enable=1 and count≠0, go to LOAD; otherwise stay.
- LOAD (exactly 1 cycle)
  - pull=1 and busy=1.
  - At the closing edge, capture `head` into the shift register.
  - Compute parity when it is compiled in.
  - Go to START.
  - The buffer advances on that same edge, so the captured word is the one that was at the head.
- START
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA
  - tx=shift[DATA_WIDTH-1].
  - Shift left by one every CLKS_PER_BIT cycles.
  - The bit index counts 0..DATA_WIDTH-1.
  - After the last bit, go to PARITY if it is compiled in, else STOP.
- PARITY
  - tx = even-parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP
  - tx=1 for CLKS_PER_BIT cycles.
  - On the final cycle's edge, pulse frame_done for the next cycle.
  - Go to LOAD if enable=1 and count≠0, else IDLE.
- Bit counter
  - $clog2(DATA_WIDTH) bits wide; no wrap beyond DATA_WIDTH-1.
- Bit timer
  - Counts 0..CLKS_PER_BIT-1.
  - `tick` asserts on terminal count.
  - Clears on every state change.
- Boundary conditions
  - count=0 in IDLE: never assert pull; no underflow requests are issued.
  - enable deasserted mid-frame: the current frame completes; no new LOAD follows.
  - count drops to 0 during a frame (another source changes it): no effect on the current frame. Only the STOP-exit check matters.
  - Reset mid-frame:
    - Next cycle: tx=1, pull=0, busy=0, frame_done=0, state IDLE.
    - The partially sent word is discarded; it is not re-pulled.
  - Reset values: tx=1, pull=0, busy=0, frame_done=0, shift register 0, counters 0.

## Timing
- Start latency: enable=1 and count≠0 sampled in IDLE. pull=1 in the next cycle, and tx falls in the cycle after LOAD.
- Frame length:
  - From the first START cycle: (DATA_WIDTH+2+P)×CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
  - With defaults and no parity: 72 cycles.
- Back-to-back frames: STOP → LOAD → START. This gives a 1-cycle gap (tx=1 during LOAD) between stop bit and next start bit.
- pull is registered from state and is never high for two consecutive cycles.
- frame_done and busy are glitch-free registered or state-decoded outputs.

## Configuration
- Macro `BUFFER_TX_PARITY_EN`.
  - Defined: PARITY state present. Parity bit = XOR of all data bits (even parity), sent after the LSB.
  - Undefined: the PARITY state, parity register and logic are absent; DATA goes directly to STOP.

## Structure
- Shared package `buffer_pkg` holds:
  - the state enum `tx_state_t` (IDLE, LOAD, START, DATA, PARITY, STOP);
  - default constants `BUF_DATA_WIDTH=16`, `BUF_COUNT_WIDTH=4`, `TX_CLKS_PER_BIT=4`.
- Sub-module `bit_timer`: parameterised CLKS_PER_BIT down-counter with `clear` input and `tick` output. It is instantiated once.

## Test plan
- Reset, then count=0 and enable=1 for 50 cycles → pull never asserted, tx=1, busy=0.
- head=16'hA5C3, count=1, enable=1, no parity → one pull pulse. tx shows 0, then bits 1010_0101_1100_0011 MSB-first, 4 cycles each, then 1. frame_done is pulsed 72 cycles after the first start-bit cycle.
- count=3 held with enable=1 → three frames, each separated by exactly one tx=1 LOAD cycle. Exactly 3 pull pulses.
- Assert reset at cycle 20 of a frame → next cycle tx=1, busy=0, state IDLE. No extra pull follows unless count≠0 and enable=1.
- With `BUFFER_TX_PARITY_EN`:
  - head=16'h0001 → parity bit 1; frame is 76 cycles.
  - head=16'h0003 → parity bit 0.
- enable dropped during DATA of frame 1 with count=2 → frame 1 completes, no second pull, returns to IDLE.
